// File: rtl/cla_pkg.sv
// Shared types, defaults and golden model for the carry-lookahead adder
// response checker.
package cla_pkg;

    localparam int          CLA_WIDTH       = 4;
    localparam int          CLA_NUM_VECTORS = 512;
    localparam logic [15:0] CLA_MISR_POLY   = 16'h1021;
    localparam logic [15:0] CLA_MISR_SEED   = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cla_state_e;

    // Ripple reference: returns {carry out of every bit, sum}.
    function automatic logic [2*CLA_WIDTH-1:0] cla_golden(
        input logic [CLA_WIDTH-1:0] a,
        input logic [CLA_WIDTH-1:0] b,
        input logic                 c0
    );
        logic [CLA_WIDTH-1:0] s;
        logic [CLA_WIDTH-1:0] c;
        logic                 cy;
        cy = c0;
        for (int k = 0; k < CLA_WIDTH; k++) begin
            s[k] = a[k] ^ b[k] ^ cy;
            cy   = (a[k] & b[k]) | (a[k] & cy) | (b[k] & cy);
            c[k] = cy;
        end
        return {c, s};
    endfunction

endpackage

// File: rtl/cla_misr.sv
// Multiple-input signature register with synchronous seed load.
module cla_misr
    import cla_pkg::*;
#(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] POLY  = CLA_MISR_POLY,
    parameter logic [WIDTH-1:0] SEED  = CLA_MISR_SEED
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] sig_o
);

    logic [WIDTH-1:0] sig_q;
    logic [WIDTH-1:0] sig_d;

    always_comb begin
        sig_d = sig_q;
        if (load_i) begin
            sig_d = SEED;
        end else if (en_i) begin
            sig_d = {sig_q[WIDTH-2:0], 1'b0}
                  ^ (sig_q[WIDTH-1] ? POLY : '0)
                  ^ data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= SEED;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig_o = sig_q;

endmodule

// File: rtl/cla_resp_checker.sv
// Two-stage response checker: registers accepted vectors, then compares
// against the golden sum, counts, captures the first failure and signs.
module cla_resp_checker
    import cla_pkg::*;
#(
    parameter int                    WIDTH       = CLA_WIDTH,
    parameter int                    NUM_VECTORS = CLA_NUM_VECTORS,
    parameter int                    MISR_WIDTH  = 16,
    parameter logic [MISR_WIDTH-1:0] MISR_POLY   = CLA_MISR_POLY,
    parameter logic [MISR_WIDTH-1:0] MISR_SEED   = CLA_MISR_SEED
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_a,
    input  logic [WIDTH-1:0]      in_b,
    input  logic                  in_c0,
    input  logic [WIDTH-1:0]      in_s,
    input  logic [WIDTH-1:0]      in_c,
    output logic [15:0]           vec_count,
    output logic [15:0]           err_count,
    output logic                  first_fail_valid,
    output logic [2*WIDTH:0]      first_fail_vec,
    output logic [2*WIDTH-1:0]    first_fail_got,
    output logic [MISR_WIDTH-1:0] signature,
    output logic                  done,
    output logic                  pass
);

    localparam int          VW = 2*WIDTH+1;
    localparam int          GW = 2*WIDTH;
    localparam logic [15:0] NV = 16'(NUM_VECTORS);

    cla_state_e      state_q, state_d;
    logic [15:0]     acc_q, acc_d;
    logic            s1_v_q, s1_v_d;
    logic [VW-1:0]   s1_vec_q, s1_vec_d;
    logic [GW-1:0]   s1_got_q, s1_got_d;
    logic [15:0]     vec_q, vec_d;
    logic [15:0]     err_q, err_d;
    logic            ffv_q, ffv_d;
    logic [VW-1:0]   ffvec_q, ffvec_d;
    logic [GW-1:0]   ffgot_q, ffgot_d;

    logic            accept;
    logic            commit;
    logic            mismatch;
    logic [GW-1:0]   exp_got;

    assign in_ready = (state_q == RUN) && (acc_q < NV);
    // start owns the cycle: no acceptance and no commit alongside it
    assign accept   = in_valid & in_ready & ~start;
    assign commit   = s1_v_q & ~start;

    assign exp_got  = cla_golden(s1_vec_q[VW-1:WIDTH+1],
                                 s1_vec_q[WIDTH:1],
                                 s1_vec_q[0]);
    assign mismatch = (s1_got_q != exp_got);

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        s1_v_d   = 1'b0;
        s1_vec_d = s1_vec_q;
        s1_got_d = s1_got_q;
        vec_d    = vec_q;
        err_d    = err_q;
        ffv_d    = ffv_q;
        ffvec_d  = ffvec_q;
        ffgot_d  = ffgot_q;
        if (start) begin
            state_d  = RUN;
            acc_d    = '0;
            vec_d    = '0;
            err_d    = '0;
            ffv_d    = 1'b0;
            ffvec_d  = '0;
            ffgot_d  = '0;
        end else begin
            s1_v_d = accept;
            if (accept) begin
                acc_d    = acc_q + 16'd1;
                s1_vec_d = {in_a, in_b, in_c0};
                s1_got_d = {in_c, in_s};
            end
            if (commit) begin
                vec_d = vec_q + 16'd1;
                if (mismatch && (err_q != 16'hFFFF)) begin
                    err_d = err_q + 16'd1;
                end
                if (mismatch && !ffv_q) begin
                    ffv_d   = 1'b1;
                    ffvec_d = s1_vec_q;
                    ffgot_d = s1_got_q;
                end
                if (vec_q == NV - 16'd1) begin
                    state_d = DONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            s1_v_q   <= 1'b0;
            s1_vec_q <= '0;
            s1_got_q <= '0;
            vec_q    <= '0;
            err_q    <= '0;
            ffv_q    <= 1'b0;
            ffvec_q  <= '0;
            ffgot_q  <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            s1_v_q   <= s1_v_d;
            s1_vec_q <= s1_vec_d;
            s1_got_q <= s1_got_d;
            vec_q    <= vec_d;
            err_q    <= err_d;
            ffv_q    <= ffv_d;
            ffvec_q  <= ffvec_d;
            ffgot_q  <= ffgot_d;
        end
    end

    cla_misr #(
        .WIDTH (MISR_WIDTH),
        .POLY  (MISR_POLY),
        .SEED  (MISR_SEED)
    ) u_misr (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (start),
        .en_i   (commit),
        .data_i ({{(MISR_WIDTH-GW){1'b0}}, s1_got_q}),
        .sig_o  (signature)
    );

    assign vec_count        = vec_q;
    assign err_count        = err_q;
    assign first_fail_valid = ffv_q;
    assign first_fail_vec   = ffvec_q;
    assign first_fail_got   = ffgot_q;
    assign done             = (state_q == DONE);
    assign pass             = (state_q == DONE) && (err_q == 16'd0);

endmodule

// File: tb/tb_cla_resp_checker.sv
// Self-checking bench for cla_resp_checker: arithmetic reference model
// compared every cycle, plus hand-computed literal expectations.
module tb_cla_resp_checker;

    localparam int NV = 512;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_a = '0, in_b = '0, in_s = '0, in_c = '0;
    logic        in_c0 = 1'b0;
    logic [15:0] vec_count, err_count, signature;
    logic        first_fail_valid, done, pass;
    logic [8:0]  first_fail_vec;
    logic [7:0]  first_fail_got;

    always #5 clk = ~clk;

    cla_resp_checker dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_a             (in_a),
        .in_b             (in_b),
        .in_c0            (in_c0),
        .in_s             (in_s),
        .in_c             (in_c),
        .vec_count        (vec_count),
        .err_count        (err_count),
        .first_fail_valid (first_fail_valid),
        .first_fail_vec   (first_fail_vec),
        .first_fail_got   (first_fail_got),
        .signature        (signature),
        .done             (done),
        .pass             (pass)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 0;

    bit          m_run, m_done, m_pv, m_ffv;
    int          m_acc, m_vec, m_err;
    logic [8:0]  m_pvec, m_ffvec;
    logic [7:0]  m_pgot, m_ffgot;
    logic [15:0] m_sig;
    logic [15:0] gapless_sig;

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference sum/carries from plain integer addition of the low bits.
    function automatic logic [7:0] gold(int a, int b, int c0);
        logic [3:0] c;
        int full;
        full = a + b + c0;
        for (int k = 0; k < 4; k++) begin
            int m;
            m = (1 << (k + 1)) - 1;
            c[k] = ((((a & m) + (b & m) + c0) >> (k + 1)) % 2) != 0;
        end
        return {c, 4'(full % 16)};
    endfunction

    task automatic model_reset();
        m_run = 0; m_done = 0; m_pv = 0; m_ffv = 0;
        m_acc = 0; m_vec = 0; m_err = 0;
        m_pvec = '0; m_pgot = '0; m_ffvec = '0; m_ffgot = '0;
        m_sig = 16'hFFFF;
    endtask

    task automatic model_step();
        bit rdy;
        bit mis;
        logic [15:0] t;
        rdy = m_run && (m_acc < NV);
        if (start) begin
            model_reset();
            m_run = 1;
        end else begin
            if (m_pv) begin
                mis = (m_pgot != gold(int'(m_pvec[8:5]), int'(m_pvec[4:1]),
                                      int'(m_pvec[0])));
                m_vec++;
                if (mis && m_err < 65535) m_err++;
                if (mis && !m_ffv) begin
                    m_ffv = 1; m_ffvec = m_pvec; m_ffgot = m_pgot;
                end
                t = m_sig << 1;
                m_sig = t ^ (m_sig[15] ? 16'h1021 : 16'h0) ^ {8'h00, m_pgot};
                if (m_vec == NV) begin
                    m_run = 0; m_done = 1;
                end
            end
            m_pv = 0;
            if (rdy && in_valid) begin
                m_pv = 1;
                m_pvec = {in_a, in_b, in_c0};
                m_pgot = {in_c, in_s};
                m_acc++;
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("in_ready", 32'(in_ready), 32'(m_run && (m_acc < NV)));
                chk("vec_count", 32'(vec_count), 32'(m_vec));
                chk("err_count", 32'(err_count), 32'(m_err));
                chk("ff_valid", 32'(first_fail_valid), 32'(m_ffv));
                chk("ff_vec", 32'(first_fail_vec), 32'(m_ffvec));
                chk("ff_got", 32'(first_fail_got), 32'(m_ffgot));
                chk("signature", 32'(signature), 32'(m_sig));
                chk("done", 32'(done), 32'(m_done));
                chk("pass", 32'(pass), 32'(m_done && m_err == 0));
            end
        end
    end

    task automatic do_start();
        @(negedge clk);
        start = 1; in_valid = 0;
        @(negedge clk);
        start = 0;
    endtask

    // Sends up to lim vectors in a/b/c0 order, two optional faulty responses.
    task automatic sweep(int lim, int f1, logic [7:0] g1,
                         int f2, logic [7:0] g2, bit gaps);
        int n;
        logic [7:0] r;
        n = 0;
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int c = 0; c < 2; c++) begin
                    if (n < lim) begin
                        if (gaps && $urandom_range(0, 3) == 0) begin
                            @(negedge clk);
                            in_valid = 0;
                            repeat ($urandom_range(0, 2)) @(negedge clk);
                        end
                        r = gold(a, b, c);
                        if ((a * 32 + b * 2 + c) == f1) r = g1;
                        if ((a * 32 + b * 2 + c) == f2) r = g2;
                        @(negedge clk);
                        in_valid = 1;
                        in_a = 4'(a); in_b = 4'(b); in_c0 = c[0];
                        in_c = r[7:4]; in_s = r[3:0];
                        n++;
                    end
                end
    endtask

    task automatic finish_run();
        @(negedge clk);
        in_valid = 0;
        for (int i = 0; i < 20 && !done; i++) @(negedge clk);
        chk("done_wait", 32'(done), 32'd1);
    endtask

    initial begin
        #12 rst_n = 0;
        #1 chk_en = 1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        chk("rst_vec", 32'(vec_count), 32'd0);
        chk("rst_sig", 32'(signature), 32'hFFFF);
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_done", 32'(done), 32'd0);

        // Vectors offered while idle are ignored.
        in_valid = 1; in_a = 4'h3; in_b = 4'h4;
        repeat (3) @(negedge clk);
        in_valid = 0;
        chk("idle_vec", 32'(vec_count), 32'd0);

        // Two hand-signed vectors: 0+0+0 -> 8'h00, 1+1+0 -> 8'h12.
        do_start();
        in_valid = 1; in_a = 0; in_b = 0; in_c0 = 0; in_c = 0; in_s = 0;
        @(negedge clk);
        in_a = 1; in_b = 1; in_c = 4'h1; in_s = 4'h2;
        @(negedge clk);
        in_valid = 0;
        @(negedge clk);
        chk("lit_sig2", 32'(signature), 32'hCF8D);
        chk("lit_vec2", 32'(vec_count), 32'd2);

        // Clean exhaustive sweep, then extra vectors in DONE are ignored.
        do_start();
        sweep(NV, -1, 8'h0, -1, 8'h0, 0);
        finish_run();
        gapless_sig = m_sig;
        in_valid = 1;
        repeat (3) @(negedge clk);
        in_valid = 0;
        chk("clean_vec", 32'(vec_count), 32'd512);
        chk("clean_err", 32'(err_count), 32'd0);
        chk("clean_pass", 32'(pass), 32'd1);

        // Sum-only fault on 7+9+1.
        do_start();
        sweep(NV, 7*32 + 9*2 + 1, 8'hF0, -1, 8'h0, 0);
        finish_run();
        chk("sf_err", 32'(err_count), 32'd1);
        chk("sf_vec", 32'(first_fail_vec), 32'(9'b0111_1001_1));
        chk("sf_got", 32'(first_fail_got), 32'h0F0);
        chk("sf_pass", 32'(pass), 32'd0);

        // Carry-only fault on F+1+0, then a later sum fault on F+F+1.
        do_start();
        sweep(NV, 15*32 + 1*2, 8'h70, 15*32 + 15*2 + 1, 8'hF0, 0);
        finish_run();
        chk("cf_err", 32'(err_count), 32'd2);
        chk("cf_vec", 32'(first_fail_vec), 32'(9'b1111_0001_0));
        chk("cf_got", 32'(first_fail_got), 32'h070);

        // Restart with a vector in flight and a vector alongside start.
        do_start();
        sweep(101, -1, 8'h0, -1, 8'h0, 0);
        @(negedge clk);
        start = 1; in_valid = 1; in_a = 4'h5; in_b = 4'h6;
        @(negedge clk);
        start = 0; in_valid = 0;
        chk("rs_vec", 32'(vec_count), 32'd0);
        chk("rs_sig", 32'(signature), 32'hFFFF);
        sweep(NV, -1, 8'h0, -1, 8'h0, 0);
        finish_run();
        chk("rs_full", 32'(vec_count), 32'd512);

        // Gapped sweep must sign identically to the gapless one.
        do_start();
        sweep(NV, -1, 8'h0, -1, 8'h0, 1);
        finish_run();
        chk("gap_sig", 32'(signature), 32'(gapless_sig));
        chk("gap_vec", 32'(vec_count), 32'd512);

        // Asynchronous reset in the middle of a run.
        do_start();
        sweep(50, -1, 8'h0, -1, 8'h0, 0);
        #2 rst_n = 0;
        #1 chk("ar_vec", 32'(vec_count), 32'd0);
        chk("ar_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        in_valid = 0;
        rst_n = 1;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
